// File: rtl/e203_fpga_shell.sv
// Pad, clock and reset shell between the FPGA pins and the E203 core.
// Holds the reset stretcher, the always-on tick divider and all pad synchronisers.
module e203_fpga_shell #(
  parameter int GPIO_W      = 32,
  parameter int LFCLK_DIV   = 1526,
  parameter int RST_STRETCH = 16
) (
  input  logic              CLK50MHZ,
  input  logic              RESETN,
  inout  wire  [GPIO_W-1:0] GPIOA,
  inout  wire  [GPIO_W-1:0] GPIOB,
  input  logic              JTAG_TCK,
  input  logic              JTAG_TDI,
  input  logic              JTAG_TMS,
  inout  wire               JTAG_TDO,
  output logic              PMU_PADRST,
  output logic              PMU_PADEN,
  output logic              core_clk,
  output logic              core_rst_n,
  output logic              lfclk_en,
  input  logic [GPIO_W-1:0] core_gpioa_o,
  input  logic [GPIO_W-1:0] core_gpioa_oe,
  output logic [GPIO_W-1:0] core_gpioa_i,
  input  logic [GPIO_W-1:0] core_gpiob_o,
  input  logic [GPIO_W-1:0] core_gpiob_oe,
  output logic [GPIO_W-1:0] core_gpiob_i,
  output logic              core_jtag_tck,
  output logic              core_jtag_tdi,
  output logic              core_jtag_tms,
  input  logic              core_jtag_tdo,
  input  logic              core_jtag_tdo_oe,
  input  logic              core_pmu_padrst,
  input  logic              core_pmu_paden
);
  localparam int RW = $clog2(RST_STRETCH + 1);
  localparam int DW = $clog2(LFCLK_DIV);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_STRETCH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(LFCLK_DIV - 1);

  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic [DW-1:0]     div_q, div_d;
  logic [GPIO_W-1:0] gpioa_s1_q, gpioa_s2_q, gpiob_s1_q, gpiob_s2_q;
  logic [2:0]        jtag_s1_q, jtag_s2_q;
  logic              padrst_q, paden_q;

  assign core_clk = CLK50MHZ;

  // Release happens on the edge where the count already sits at RST_STRETCH-1,
  // i.e. the RST_STRETCH-th edge with RESETN low.
  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    core_rst_n_d = core_rst_n_q;
    if (!core_rst_n_q) begin
      if (rst_cnt_q == RST_LAST) core_rst_n_d = 1'b1;
      else                       rst_cnt_d    = rst_cnt_q + 1'b1;
    end
  end

  always_comb begin
    div_d = '0;
    if (core_rst_n_q && div_q != DIV_LAST) div_d = div_q + 1'b1;
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RESETN) begin
      rst_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
      div_q        <= '0;
      gpioa_s1_q   <= '1;
      gpioa_s2_q   <= '1;
      gpiob_s1_q   <= '1;
      gpiob_s2_q   <= '1;
      jtag_s1_q    <= '0;
      jtag_s2_q    <= '0;
      padrst_q     <= 1'b1;
      paden_q      <= 1'b0;
    end else begin
      rst_cnt_q    <= rst_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      div_q        <= div_d;
      gpioa_s1_q   <= GPIOA;
      gpioa_s2_q   <= gpioa_s1_q;
      gpiob_s1_q   <= GPIOB;
      gpiob_s2_q   <= gpiob_s1_q;
      jtag_s1_q    <= {JTAG_TCK, JTAG_TDI, JTAG_TMS};
      jtag_s2_q    <= jtag_s1_q;
      // Gate on the next reset state so PMU pads follow the core exactly while it runs.
      padrst_q     <= core_rst_n_d ? core_pmu_padrst : 1'b1;
      paden_q      <= core_rst_n_d ? core_pmu_paden  : 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_pad
      assign GPIOA[gi] = core_gpioa_oe[gi] ? core_gpioa_o[gi] : 1'bz;
      assign GPIOB[gi] = core_gpiob_oe[gi] ? core_gpiob_o[gi] : 1'bz;
    end
  endgenerate

  assign JTAG_TDO      = core_jtag_tdo_oe ? core_jtag_tdo : 1'bz;
  assign core_rst_n    = core_rst_n_q;
  assign lfclk_en      = core_rst_n_q && (div_q == DIV_LAST);
  assign core_gpioa_i  = gpioa_s2_q;
  assign core_gpiob_i  = gpiob_s2_q;
  assign core_jtag_tck = jtag_s2_q[2];
  assign core_jtag_tdi = jtag_s2_q[1];
  assign core_jtag_tms = jtag_s2_q[0];
  assign PMU_PADRST    = padrst_q;
  assign PMU_PADEN     = paden_q;
endmodule

// File: tb/tb_e203_fpga_shell.sv
// Directed bench for e203_fpga_shell: reset stretch, tick divider, pads, JTAG and PMU.
module tb_e203_fpga_shell;
  logic        clk = 1'b0;
  logic        resetn;
  wire  [31:0] gpioa, gpiob;
  wire         jtag_tdo;
  logic        jtag_tck, jtag_tdi, jtag_tms;
  logic        pmu_padrst, pmu_paden, core_clk, core_rst_n, lfclk_en;
  logic [31:0] gpioa_o, gpioa_oe, gpioa_i, gpiob_o, gpiob_oe, gpiob_i;
  logic        c_tck, c_tdi, c_tms, c_tdo, c_tdo_oe, c_padrst, c_paden;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          t_rise, t_pulse;
  logic        found;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_pu
      pullup (gpioa[gi]);
      pullup (gpiob[gi]);
    end
  endgenerate
  pulldown (jtag_tdo);

  e203_fpga_shell dut (
    .CLK50MHZ(clk), .RESETN(resetn), .GPIOA(gpioa), .GPIOB(gpiob),
    .JTAG_TCK(jtag_tck), .JTAG_TDI(jtag_tdi), .JTAG_TMS(jtag_tms), .JTAG_TDO(jtag_tdo),
    .PMU_PADRST(pmu_padrst), .PMU_PADEN(pmu_paden), .core_clk(core_clk),
    .core_rst_n(core_rst_n), .lfclk_en(lfclk_en),
    .core_gpioa_o(gpioa_o), .core_gpioa_oe(gpioa_oe), .core_gpioa_i(gpioa_i),
    .core_gpiob_o(gpiob_o), .core_gpiob_oe(gpiob_oe), .core_gpiob_i(gpiob_i),
    .core_jtag_tck(c_tck), .core_jtag_tdi(c_tdi), .core_jtag_tms(c_tms),
    .core_jtag_tdo(c_tdo), .core_jtag_tdo_oe(c_tdo_oe),
    .core_pmu_padrst(c_padrst), .core_pmu_paden(c_paden)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    resetn = 1'b1;
    jtag_tck = 0; jtag_tdi = 0; jtag_tms = 0;
    gpioa_o = '0; gpioa_oe = '0; gpiob_o = '0; gpiob_oe = '0;
    c_tdo = 0; c_tdo_oe = 0; c_padrst = 0; c_paden = 1;
    tick(50);
    check("rst_core_rst_n", 32'(core_rst_n), 32'h0);
    check("rst_lfclk_en",   32'(lfclk_en),   32'h0);
    check("rst_padrst",     32'(pmu_padrst), 32'h1);
    check("rst_paden",      32'(pmu_paden),  32'h0);
    check("rst_gpioa_i",    gpioa_i,         32'hFFFF_FFFF);
    check("rst_gpiob_i",    gpiob_i,         32'hFFFF_FFFF);
    check("rst_jtag",       {29'd0, c_tck, c_tdi, c_tms}, 32'h0);
    check("clk_passthru",   32'(core_clk),   32'(clk));

    // Release: low for 15 edges, high on the 16th
    resetn = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check($sformatf("stretch_e%0d", e), 32'(core_rst_n), 32'h0);
    end
    check("padrst_held", 32'(pmu_padrst), 32'h1);
    tick();
    t_rise = cyc;
    check("stretch_e16",  32'(core_rst_n), 32'h1);
    check("run_padrst",   32'(pmu_padrst), 32'h0);
    check("run_paden",    32'(pmu_paden),  32'h1);

    c_padrst = 1;
    check("pmu_lat0", 32'(pmu_padrst), 32'h0);
    tick();
    check("pmu_lat1", 32'(pmu_padrst), 32'h1);

    // GPIO bank A
    check("gpa_pullup", gpioa_i, 32'hFFFF_FFFF);
    gpioa_oe = 32'h0000_00FF; gpioa_o = 32'h0000_00A5;
    #1;
    check("gpa_pad", gpioa, 32'hFFFF_FFA5);
    tick();
    check("gpa_sync1", gpioa_i, 32'hFFFF_FFFF);
    tick();
    check("gpa_sync2", gpioa_i, 32'hFFFF_FFA5);

    // GPIO bank B
    gpiob_oe = 32'hFFFF_FFFF; gpiob_o = 32'h1234_5678;
    #1;
    check("gpb_pad", gpiob, 32'h1234_5678);
    check("gpa_pad_keep", gpioa, 32'hFFFF_FFA5);
    tick(2);
    check("gpb_sync2", gpiob_i, 32'h1234_5678);
    check("gpa_unaff", gpioa_i, 32'hFFFF_FFA5);

    // JTAG
    #1;
    check("tdo_pulldown", 32'(jtag_tdo), 32'h0);
    c_tdo_oe = 1; c_tdo = 1;
    #1;
    check("tdo_driven", 32'(jtag_tdo), 32'h1);
    jtag_tms = 1;
    tick();
    check("tms_sync1", 32'(c_tms), 32'h0);
    tick();
    check("tms_sync2", 32'(c_tms), 32'h1);
    jtag_tdi = 1; jtag_tck = 1;
    tick(2);
    check("tdi_tck_sync", {30'd0, c_tck, c_tdi}, 32'h3);

    // lfclk_en: first pulse 1525 edges after release, then every 1526
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (lfclk_en) found = 1'b1;
      else tick();
    end
    check("lf_first_found", 32'(found), 32'h1);
    check("lf_first_time",  32'(cyc - t_rise), 32'd1525);
    t_pulse = cyc;
    tick();
    check("lf_width", 32'(lfclk_en), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (lfclk_en) found = 1'b1;
      else tick();
    end
    check("lf_second_found", 32'(found), 32'h1);
    check("lf_spacing", 32'(cyc - t_pulse), 32'd1526);

    // Reset on the cycle before a pulse would fire
    tick(1525);
    resetn = 1'b1;
    tick();
    check("mid_lfclk_en",   32'(lfclk_en),   32'h0);
    check("mid_core_rst_n", 32'(core_rst_n), 32'h0);
    check("mid_padrst",     32'(pmu_padrst), 32'h1);
    check("mid_gpioa_i",    gpioa_i,         32'hFFFF_FFFF);
    resetn = 1'b0;
    tick(15);
    check("restart_e15", 32'(core_rst_n), 32'h0);
    tick();
    check("restart_e16", 32'(core_rst_n), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
